jump_button_poller: RTL
=======================

# jump_button_poller

Avalon-MM master that polls the jump-button PIO slave and turns its raw level into a debounced game event. It reads register address 0 at a fixed poll interval and applies a consecutive-sample debounce filter to bit 0. It emits a single-cycle `jump_pulse` on each debounced press and keeps a wrapping press counter. It sits between the button PIO and game logic, so the game no longer needs CPU polling.

## Interface
Parameters:
- `POLL_CYCLES`, 50000: clock cycles spent idle between reads (1 ms at 50 MHz); must be ≥1.
- `DEBOUNCE_SAMPLES`, 4: consecutive identical samples required to change debounced state; must be ≥1.
- `READ_LATENCY`, 1: fixed slave read latency in cycles after acceptance; must be ≥1.
- `ACTIVE_LOW`, 1: 1 means a raw `0` is "pressed" (DE-board keys).

Ports:
- `clk` in 1: the block's single clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `avm_address` out 2: always 2'd0 while `avm_read`=1; 0 otherwise.
- `avm_read` out 1: read request.
- `avm_waitrequest` in 1: slave stall; a read is accepted on the edge where `avm_read`=1 and `avm_waitrequest`=0.
- `avm_readdata` in 32: slave data; only bit 0 is used.
- `pressed` out 1: debounced button level (1 = pressed).
- `jump_pulse` out 1: one-cycle strobe on each debounced 0→1 transition of `pressed`.
- `press_count` out 16: number of debounced presses, wrapping.

## Operation
- FSM has three states: IDLE, READ and WAIT.
  - IDLE: `poll_cnt` loads `POLL_CYCLES-1` on entry and decrements each cycle. When it reaches 0, the FSM moves to READ. IDLE therefore lasts exactly `POLL_CYCLES` cycles.
  - READ: `avm_read`=1 and `avm_address`=0. Both are held stable while `avm_waitrequest`=1. On acceptance, the FSM moves to WAIT with `lat_cnt`=`READ_LATENCY-1`.
  - WAIT: `lat_cnt` decrements each cycle. At the edge ending the cycle where `lat_cnt`=0, `avm_readdata[0]` is sampled and the FSM returns to IDLE.
- Sample value: `s = avm_readdata[0] ^ ACTIVE_LOW`.
- Debounce rule, applied at each sample edge:
  - If `s == pressed`, `stable_cnt` is cleared to 0.
  - Otherwise, if `stable_cnt+1 == DEBOUNCE_SAMPLES`, then `pressed` ← `s` and `stable_cnt` ← 0. If `s`=1, `jump_pulse` ← 1 and `press_count` increments.
  - Otherwise, `stable_cnt` increments.
- `stable_cnt` width is `$clog2(DEBOUNCE_SAMPLES+1)`. `press_count` wraps from 0xFFFF to 0x0000 with no flag.
- `jump_pulse` is cleared on the following edge. Because presses require at least one full poll period, pulses can never be back-to-back.
- Releases (debounced 1→0) update `pressed` only: no pulse and no count change.

## Timing
- Reset values: `avm_read`=0, `avm_address`=0, `pressed`=0, `jump_pulse`=0, `press_count`=0. Internally, `stable_cnt`=0, FSM=IDLE and `poll_cnt`=`POLL_CYCLES-1`.
- First `avm_read` is asserted in cycle `POLL_CYCLES` after reset deassertion (cycle 0 = first edge with `reset_n`=1).
- Poll period with no stalls is `POLL_CYCLES + 1 + READ_LATENCY` cycles. Each stall cycle adds one cycle.
- `pressed`, `jump_pulse` and `press_count` all update on the same sample edge. `jump_pulse` is high for exactly the following cycle.
- All outputs are registered; there is no combinational path from any input to any output.
- Reset mid-transaction: `avm_read` drops asynchronously and all state clears. Any late `avm_readdata` is ignored.
- `avm_waitrequest` is ignored outside READ. `avm_readdata` is ignored outside the sample edge.

## Structure
- Package `jump_button_pkg` holds:
  - state enum `poll_state_t` (IDLE, READ, WAIT);
  - constant `JB_DATA_ADDR` = 2'd0;
  - constant `PRESS_COUNT_W` = 16.
- Sub-module `jump_debounce` contains `stable_cnt`, `pressed`, `jump_pulse` and `press_count`.
  - Inputs: `clk`, `reset_n`, `sample_valid`, `sample`. `sample_valid` is a one-cycle strobe from the FSM.
  - Parameter: `DEBOUNCE_SAMPLES`.
- Top level holds the FSM, `poll_cnt`, `lat_cnt` and the polarity XOR.

## Test plan
All scenarios use `POLL_CYCLES`=4, `DEBOUNCE_SAMPLES`=3, `READ_LATENCY`=1, `ACTIVE_LOW`=1 and `avm_waitrequest`=0 unless stated.
- Reset and idle: hold `avm_readdata`=1 → all outputs 0. `avm_read`=1 with address 0 first in cycle 4, then every 6 cycles; `pressed` stays 0.
- Clean press: `avm_readdata`=0 from cycle 0 → `pressed`=1 after the 3rd sample. `jump_pulse` is high for exactly one cycle, and `press_count`=1.
- Bounce: raw samples 0,1,0,0,1,1 → `pressed` stays 0, no `jump_pulse`, `press_count`=0.
- Stall: `avm_waitrequest`=1 for 5 cycles during the first READ → `avm_read` and address are held stable for 6 cycles. The sample is taken 1 cycle after acceptance, and the next read starts 5 cycles later than unstalled.
- Release and wrap: preload 0xFFFF presses via the debounce path, then press → `press_count`=0x0000. Then release for 3 samples → `pressed`=0, no pulse, count unchanged.
- Reset mid-read: drive `reset_n`=0 while `avm_read`=1 → `avm_read`=0 immediately and all outputs 0. After release, the first read occurs in cycle 4 again.

Source files
------------

// File: rtl/jump_button_pkg.sv
// jump_button_pkg
//   Shared types and constants for the jump-button poller.
//   - poll_state_t  : poller FSM states (IDLE, READ, WAIT)
//   - JB_DATA_ADDR  : PIO register address holding the raw button level
//   - PRESS_COUNT_W : width of the wrapping press counter
package jump_button_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2
  } poll_state_t;

  localparam logic [1:0] JB_DATA_ADDR  = 2'd0;
  localparam int         PRESS_COUNT_W = 16;

endpackage

// File: rtl/jump_debounce.sv
// jump_debounce
//   Consecutive-sample debounce filter with press detection.
//   Ports:
//     clk, reset_n  : clock, asynchronous active-low reset
//     sample_valid  : one-cycle strobe marking a new sample
//     sample        : polarity-corrected sample (1 = pressed)
//     pressed       : debounced level
//     jump_pulse    : one-cycle strobe on each debounced 0->1 transition
//     press_count   : wrapping count of debounced presses
module jump_debounce
  import jump_button_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int COUNT_W          = PRESS_COUNT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sample_valid,
  input  logic               sample,
  output logic               pressed,
  output logic               jump_pulse,
  output logic [COUNT_W-1:0] press_count
);

  localparam int STABLE_W = $clog2(DEBOUNCE_SAMPLES + 1);
  // The sample that completes the run arrives when the counter already
  // holds DEBOUNCE_SAMPLES-1 disagreeing samples.
  localparam logic [STABLE_W-1:0] LAST_CNT = STABLE_W'(DEBOUNCE_SAMPLES - 1);

  logic [STABLE_W-1:0] stable_cnt_reg;
  logic                pressed_reg;
  logic                jump_pulse_reg;
  logic [COUNT_W-1:0]  press_count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_cnt_reg  <= '0;
      pressed_reg     <= 1'b0;
      jump_pulse_reg  <= 1'b0;
      press_count_reg <= '0;
    end else begin
      jump_pulse_reg <= 1'b0;
      if (sample_valid) begin
        if (sample == pressed_reg) begin
          // Any agreeing sample breaks a run of disagreeing ones.
          stable_cnt_reg <= '0;
        end else if (stable_cnt_reg == LAST_CNT) begin
          pressed_reg    <= sample;
          stable_cnt_reg <= '0;
          if (sample) begin
            jump_pulse_reg  <= 1'b1;
            press_count_reg <= press_count_reg + 1'b1;
          end
        end else begin
          stable_cnt_reg <= stable_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign pressed     = pressed_reg;
  assign jump_pulse  = jump_pulse_reg;
  assign press_count = press_count_reg;

endmodule

// File: rtl/jump_button_poller.sv
// jump_button_poller
//   Avalon-MM master that periodically reads the jump-button PIO and turns
//   bit 0 of the read data into a debounced press level, press strobe and
//   wrapping press counter.
//   Ports:
//     clk, reset_n     : clock, asynchronous active-low reset
//     avm_address      : read address (always JB_DATA_ADDR)
//     avm_read         : registered read request
//     avm_waitrequest  : slave stall, honoured only while reading
//     avm_readdata     : slave data, bit 0 is the raw button level
//     pressed          : debounced level (1 = pressed)
//     jump_pulse       : one-cycle strobe per debounced press
//     press_count      : wrapping press counter
module jump_button_poller
  import jump_button_pkg::*;
#(
  parameter int POLL_CYCLES      = 50000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int READ_LATENCY     = 1,
  parameter bit ACTIVE_LOW       = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic [1:0]               avm_address,
  output logic                     avm_read,
  input  logic                     avm_waitrequest,
  input  logic [31:0]              avm_readdata,
  output logic                     pressed,
  output logic                     jump_pulse,
  output logic [PRESS_COUNT_W-1:0] press_count
);

  localparam int POLL_W = $clog2(POLL_CYCLES + 1);
  localparam int LAT_W  = $clog2(READ_LATENCY + 1);
  localparam logic [POLL_W-1:0] POLL_LOAD = POLL_W'(POLL_CYCLES - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(READ_LATENCY - 1);

  poll_state_t       state_reg;
  logic [POLL_W-1:0] poll_cnt_reg;
  logic [LAT_W-1:0]  lat_cnt_reg;
  logic              avm_read_reg;

  logic sample_valid;
  logic sample;
  logic unused_readdata_bits;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      poll_cnt_reg <= POLL_LOAD;
      lat_cnt_reg  <= '0;
      avm_read_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (poll_cnt_reg == '0) begin
            state_reg    <= READ;
            avm_read_reg <= 1'b1;
          end else begin
            poll_cnt_reg <= poll_cnt_reg - 1'b1;
          end
        end
        READ: begin
          // Request stays up, unchanged, until the slave accepts it.
          if (!avm_waitrequest) begin
            state_reg    <= WAIT;
            avm_read_reg <= 1'b0;
            lat_cnt_reg  <= LAT_LOAD;
          end
        end
        WAIT: begin
          if (lat_cnt_reg == '0) begin
            state_reg    <= IDLE;
            poll_cnt_reg <= POLL_LOAD;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg    <= IDLE;
          poll_cnt_reg <= POLL_LOAD;
          avm_read_reg <= 1'b0;
        end
      endcase
    end
  end

  // Read data is valid during the last WAIT cycle; that edge is the sample edge.
  assign sample_valid = (state_reg == WAIT) && (lat_cnt_reg == '0);
  assign sample       = avm_readdata[0] ^ ACTIVE_LOW;

  assign unused_readdata_bits = ^avm_readdata[31:1];

  assign avm_read    = avm_read_reg;
  assign avm_address = JB_DATA_ADDR;

  jump_debounce #(
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES),
    .COUNT_W         (PRESS_COUNT_W)
  ) u_debounce (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_valid(sample_valid),
    .sample      (sample),
    .pressed     (pressed),
    .jump_pulse  (jump_pulse),
    .press_count (press_count)
  );

endmodule
